// File: rtl/dial_pkg.sv
// ============================================================================
// Package     : dial_pkg
// Description : Shared constants and state encoding for the dial command sequencer
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package dial_pkg;

    localparam int SOL_LAT = 4;

    // A bubble is a right rotation by zero clicks: position and counters unchanged.
    localparam int   BUBBLE_AMOUNT = 0;
    localparam logic BUBBLE_DIR    = 1'b1;

    // FIFO entry layout is {last, dir_r, amount}; two flag bits sit above the amount.
    localparam int ENTRY_FLAG_BITS = 2;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_CLEAR = 3'd1;
    localparam state_t ST_RUN   = 3'd2;
    localparam state_t ST_DRAIN = 3'd3;
    localparam state_t ST_DONE  = 3'd4;

endpackage

`default_nettype wire

// File: rtl/dial_cmd_fifo.sv
// ============================================================================
// Module      : dial_cmd_fifo
// Description : Synchronous DEPTH x WIDTH FIFO with full/empty and synchronous flush
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dial_cmd_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 34
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == FULL_COUNT);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push && !rst && !flush) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers rely on natural wrap since DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (do_push && !do_pop) begin
                count <= count + (AW + 1)'(1);
            end else if (do_pop && !do_push) begin
                count <= count - (AW + 1)'(1);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/dial_cmd_sequencer.sv
// ============================================================================
// Module      : dial_cmd_sequencer
// Description : Buffers rotation commands and feeds the pipelined dial solver
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dial_cmd_sequencer
    import dial_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int LAT   = SOL_LAT,
    parameter int W     = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         pause,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic         cmd_dir_r,
    input  logic [W-1:0] cmd_amount,
    input  logic         cmd_last,
    output logic         sol_rst,
    output logic [W-1:0] sol_in_data,
    output logic         sol_dir_r,
    input  logic [W-1:0] sol_zero_count,
    input  logic [W-1:0] sol_zero_crossings,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] res_zero_count,
    output logic [W-1:0] res_zero_crossings,
    output logic [W-1:0] cmd_count
);

    localparam int EW = W + ENTRY_FLAG_BITS;
    localparam int DW = $clog2(LAT + 2) + 1;
    localparam logic [DW-1:0] DRAIN_START = DW'(LAT + 1);

    state_t        state;
    logic          last_seen;
    logic [DW-1:0] drain_cnt;
    logic          fifo_full;
    logic          fifo_empty;
    logic          push;
    logic          pop;
    logic [EW-1:0] head;
    logic          head_last;
    logic          head_dir;
    logic [W-1:0]  head_amount;

    assign cmd_ready   = (state == ST_RUN) && !fifo_full && !last_seen;
    assign push        = cmd_valid && cmd_ready;
    assign pop         = (state == ST_RUN) && !fifo_empty && !pause;
    assign head_last   = head[W+1];
    assign head_dir    = head[W];
    assign head_amount = head[W-1:0];
    assign busy        = (state == ST_CLEAR) || (state == ST_RUN) || (state == ST_DRAIN);
    assign sol_rst     = rst || (state == ST_CLEAR);

    dial_cmd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (EW)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (state == ST_CLEAR),
        .push  (push),
        .wdata ({cmd_last, cmd_dir_r, cmd_amount}),
        .pop   (pop),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state              <= ST_IDLE;
            last_seen          <= 1'b0;
            drain_cnt          <= '0;
            sol_in_data        <= W'(BUBBLE_AMOUNT);
            sol_dir_r          <= BUBBLE_DIR;
            done               <= 1'b0;
            res_zero_count     <= '0;
            res_zero_crossings <= '0;
            cmd_count          <= '0;
        end else begin
            // Every cycle that does not issue a command feeds the solver a bubble.
            sol_in_data <= W'(BUBBLE_AMOUNT);
            sol_dir_r   <= BUBBLE_DIR;
            done        <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state <= ST_CLEAR;
                    end
                end
                ST_CLEAR: begin
                    last_seen          <= 1'b0;
                    cmd_count          <= '0;
                    res_zero_count     <= '0;
                    res_zero_crossings <= '0;
                    state              <= ST_RUN;
                end
                ST_RUN: begin
                    if (push && cmd_last) begin
                        last_seen <= 1'b1;
                    end
                    if (pop) begin
                        sol_in_data <= head_amount;
                        sol_dir_r   <= head_dir;
                        cmd_count   <= cmd_count + W'(1);
                        if (head_last) begin
                            state     <= ST_DRAIN;
                            drain_cnt <= DRAIN_START;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (drain_cnt == '0) begin
                        res_zero_count     <= sol_zero_count;
                        res_zero_crossings <= sol_zero_crossings;
                        done               <= 1'b1;
                        state              <= ST_DONE;
                    end else begin
                        drain_cnt <= drain_cnt - DW'(1);
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_dial_cmd_sequencer.sv
// ============================================================================
// Module      : tb_dial_cmd_sequencer
// Description : Directed self-checking bench with a behavioural dial solver model
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dial_cmd_sequencer;

    localparam int W     = 32;
    localparam int DEPTH = 8;
    localparam int LAT   = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         pause;
    logic         cmd_valid;
    logic         cmd_ready;
    logic         cmd_dir_r;
    logic [W-1:0] cmd_amount;
    logic         cmd_last;
    logic         sol_rst;
    logic [W-1:0] sol_in_data;
    logic         sol_dir_r;
    logic [W-1:0] sol_zero_count;
    logic [W-1:0] sol_zero_crossings;
    logic         busy;
    logic         done;
    logic [W-1:0] res_zero_count;
    logic [W-1:0] res_zero_crossings;
    logic [W-1:0] cmd_count;

    dial_cmd_sequencer #(
        .DEPTH (DEPTH),
        .LAT   (LAT),
        .W     (W)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .start              (start),
        .pause              (pause),
        .cmd_valid          (cmd_valid),
        .cmd_ready          (cmd_ready),
        .cmd_dir_r          (cmd_dir_r),
        .cmd_amount         (cmd_amount),
        .cmd_last           (cmd_last),
        .sol_rst            (sol_rst),
        .sol_in_data        (sol_in_data),
        .sol_dir_r          (sol_dir_r),
        .sol_zero_count     (sol_zero_count),
        .sol_zero_crossings (sol_zero_crossings),
        .busy               (busy),
        .done               (done),
        .res_zero_count     (res_zero_count),
        .res_zero_crossings (res_zero_crossings),
        .cmd_count          (cmd_count)
    );

    always #5 clk = ~clk;

    // Dial solver model: LAT-deep delay line then a mod-100 accumulate stage, start at 50.
    logic [W-1:0] p_amt [LAT];
    logic         p_dir [LAT];
    longint       pos;

    always @(posedge clk) begin
        longint a, np, c;
        if (sol_rst) begin
            pos                <= 50;
            sol_zero_count     <= '0;
            sol_zero_crossings <= '0;
            for (int i = 0; i < LAT; i++) begin
                p_amt[i] <= '0;
                p_dir[i] <= 1'b1;
            end
        end else begin
            a = longint'(p_amt[LAT-1]);
            if (p_dir[LAT-1]) begin
                c  = (pos + a) / 100;
                np = (pos + a) % 100;
            end else begin
                if (pos == 0)     c = a / 100;
                else if (a >= pos) c = 1 + (a - pos) / 100;
                else              c = 0;
                np = (pos + 100 - (a % 100)) % 100;
            end
            pos                <= np;
            sol_zero_crossings <= sol_zero_crossings + W'(c);
            if (np == 0 && a != 0) sol_zero_count <= sol_zero_count + 1;
            for (int i = LAT - 1; i > 0; i--) begin
                p_amt[i] <= p_amt[i-1];
                p_dir[i] <= p_dir[i-1];
            end
            p_amt[0] <= sol_in_data;
            p_dir[0] <= sol_dir_r;
        end
    end

    int           errors = 0;
    int           checks = 0;
    int           cyc = 0;
    int           done_cnt = 0;
    int           done_cyc = 0;
    int           issue_cyc = 0;
    logic [W-1:0] prev_cc = '0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (cmd_count != prev_cc) issue_cyc = cyc;
        prev_cc = cmd_count;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_cmd(input logic dir, input logic [W-1:0] amt, input logic last, input int gap);
        logic acc;
        acc        = 1'b0;
        cmd_valid  = 1'b1;
        cmd_dir_r  = dir;
        cmd_amount = amt;
        cmd_last   = last;
        for (int n = 0; n < 100; n++) begin
            acc = cmd_ready;
            tick();
            if (acc) break;
        end
        if (!acc) check("push_timeout", 64'(acc), 64'd1);
        cmd_valid = 1'b0;
        cmd_last  = 1'b0;
        repeat (gap) tick();
    endtask

    task automatic wait_done(input int d0);
        for (int n = 0; n < 200; n++) begin
            if (done_cnt > d0) break;
            tick();
        end
        if (done_cnt <= d0) check("done_timeout", 64'(done_cnt), 64'(d0 + 1));
    endtask

    task automatic begin_run();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    logic          ex_dir [10] = '{0, 0, 1, 0, 1, 0, 0, 0, 1, 0};
    int unsigned   ex_amt [10] = '{68, 30, 48, 5, 60, 55, 1, 99, 14, 82};

    task automatic run_example(input int gap, input string tag);
        int d0;
        d0 = done_cnt;
        begin_run();
        check({tag, "_clear_sol_rst"}, 64'(sol_rst), 64'd1);
        tick();
        check({tag, "_clear_one_cycle"}, 64'(sol_rst), 64'd0);
        for (int i = 0; i < 10; i++) push_cmd(ex_dir[i], W'(ex_amt[i]), i == 9, gap);
        wait_done(d0);
        repeat (5) tick();
        check({tag, "_done_pulses"}, 64'(done_cnt - d0), 64'd1);
        check({tag, "_zero_count"}, 64'(res_zero_count), 64'd3);
        check({tag, "_crossings"}, 64'(res_zero_crossings), 64'd6);
        check({tag, "_cmd_count"}, 64'(cmd_count), 64'd10);
        check({tag, "_done_latency"}, 64'(done_cyc - issue_cyc + 1), 64'(LAT + 3));
        check({tag, "_busy_after"}, 64'(busy), 64'd0);
    endtask

    initial begin
        int d0;
        rst = 1'b1; start = 1'b0; pause = 1'b0; cmd_valid = 1'b0;
        cmd_dir_r = 1'b0; cmd_amount = '0; cmd_last = 1'b0;
        repeat (3) tick();
        check("rst_sol_rst", 64'(sol_rst), 64'd1);
        check("rst_cmd_ready", 64'(cmd_ready), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_sol_in_data", 64'(sol_in_data), 64'd0);
        check("rst_sol_dir_r", 64'(sol_dir_r), 64'd1);
        check("rst_res_count", 64'(res_zero_count), 64'd0);
        check("rst_res_cross", 64'(res_zero_crossings), 64'd0);
        check("rst_cmd_count", 64'(cmd_count), 64'd0);
        rst = 1'b0;
        tick();
        check("idle_sol_rst", 64'(sol_rst), 64'd0);

        run_example(0, "b2b");
        run_example(3, "gappy");

        // Backpressure: fill while paused, then release and expect 8 back-to-back issues.
        d0 = done_cnt;
        begin_run();
        pause = 1'b1;
        for (int i = 0; i < 8; i++) push_cmd(1'b1, W'(50), 1'b0, 0);
        check("bp_full_ready", 64'(cmd_ready), 64'd0);
        check("bp_no_issue", 64'(cmd_count), 64'd0);
        pause = 1'b0;
        tick();
        for (int i = 0; i < 8; i++) begin
            check("bp_issue", {31'd0, sol_dir_r, sol_in_data}, {31'd0, 1'b1, 32'd50});
            if (i == 0) check("bp_ready_reassert", 64'(cmd_ready), 64'd1);
            tick();
        end
        check("bp_bubble_after", 64'(sol_in_data), 64'd0);
        check("bp_cmd_count8", 64'(cmd_count), 64'd8);
        push_cmd(1'b0, W'(50), 1'b1, 0);
        wait_done(d0);
        check("bp_zero_count", 64'(res_zero_count), 64'd5);
        check("bp_crossings", 64'(res_zero_crossings), 64'd5);
        check("bp_cmd_count", 64'(cmd_count), 64'd9);

        // Abort two cycles into DRAIN.
        d0 = done_cnt;
        begin_run();
        push_cmd(1'b1, W'(50), 1'b1, 0);
        for (int n = 0; n < 50 && cmd_count != 1; n++) tick();
        check("abort_issued", 64'(cmd_count), 64'd1);
        repeat (2) tick();
        rst = 1'b1;
        tick();
        check("abort_sol_rst", 64'(sol_rst), 64'd1);
        tick();
        rst = 1'b0;
        tick();
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_res_count", 64'(res_zero_count), 64'd0);
        check("abort_res_cross", 64'(res_zero_crossings), 64'd0);
        check("abort_cmd_count", 64'(cmd_count), 64'd0);
        repeat (12) tick();
        check("abort_no_done", 64'(done_cnt - d0), 64'd0);
        begin_run();
        push_cmd(1'b1, W'(50), 1'b1, 0);
        wait_done(d0);
        check("rerun_zero_count", 64'(res_zero_count), 64'd1);
        check("rerun_cmd_count", 64'(cmd_count), 64'd1);

        // start during RUN is ignored; nothing accepted after last.
        d0 = done_cnt;
        begin_run();
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("run_start_sol_rst", 64'(sol_rst), 64'd0);
            tick();
        end
        check("run_start_busy", 64'(busy), 64'd1);
        pause = 1'b1;
        push_cmd(1'b1, W'(0), 1'b1, 0);
        cmd_valid  = 1'b1;
        cmd_dir_r  = 1'b1;
        cmd_amount = W'(7);
        check("after_last_ready", 64'(cmd_ready), 64'd0);
        tick();
        check("after_last_ready2", 64'(cmd_ready), 64'd0);
        cmd_valid = 1'b0;
        pause     = 1'b0;
        wait_done(d0);
        check("zero_amt_cmd_count", 64'(cmd_count), 64'd1);
        check("zero_amt_zero_count", 64'(res_zero_count), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got %0d cycles expected completion", cyc);
        $fatal(1);
    end

endmodule

`default_nettype wire
